// File: rtl/bits2bytes_pkg.sv
// Shared types and constants for the serial-bit to byte packer.
// Imported by the controller and by the word splitter.
package bits2bytes_pkg;

    localparam int N_BYTES_DEF = 4;
    localparam int BYTE_W      = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/bits2bytes.sv
// Splits a packed word into N_BYTES bytes.
// Byte k is word[8k+7:8k].
module bits2bytes
    import bits2bytes_pkg::*;
#(
    parameter int N_BYTES = N_BYTES_DEF
) (
    input  logic [N_BYTES*BYTE_W-1:0]        word_i,
    output logic [N_BYTES-1:0][BYTE_W-1:0]   bytes_o
);

    for (genvar k = 0; k < N_BYTES; k++) begin : g_split
        assign bytes_o[k] = word_i[k*BYTE_W +: BYTE_W];
    end

endmodule

// File: rtl/bits_to_bytes_ctrl.sv
// Packs an LSB-first serial bit stream into words, then drains each word bytewise.
// Handshakes: a transfer happens on a rising edge where valid && ready; valid never waits on ready.
module bits_to_bytes_ctrl
    import bits2bytes_pkg::*;
#(
    parameter int N_BYTES = N_BYTES_DEF,
    parameter int LEN_W   = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic             bit_valid_i,
    input  logic             bit_i,
    output logic             bit_ready_o,
    output logic             byte_valid_o,
    output logic [7:0]       byte_o,
    input  logic             byte_ready_i,
    output logic             byte_last_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [1:0]       dbg_state_o
);

    localparam int WORD_W    = N_BYTES * BYTE_W;
    localparam int BIT_CNT_W = $clog2(WORD_W);
    localparam int IDX_W     = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;

    state_t                         r_state;
    state_t                         w_state_nxt;
    logic [LEN_W-1:0]               r_remaining;
    logic [WORD_W-1:0]              r_word;
    logic [BIT_CNT_W-1:0]           r_bit_cnt;
    logic [IDX_W-1:0]               r_byte_idx;
    logic [N_BYTES-1:0][BYTE_W-1:0] w_bytes;
    logic [LEN_W+2:0]               w_rem_bits;
    logic [BIT_CNT_W-1:0]           w_last_bit;
    logic                           w_bit_hs;
    logic                           w_byte_hs;
    logic                           w_word_end;
    logic                           w_last_byte;

    bits2bytes #(.N_BYTES(N_BYTES)) u_split (
        .word_i  (r_word),
        .bytes_o (w_bytes)
    );

    // Index of the final bit of the current word: a short tail word holds only the remaining bytes.
    assign w_rem_bits = {r_remaining, 3'b000};
    always_comb begin
        w_last_bit = BIT_CNT_W'(WORD_W - 1);
        if (r_remaining < LEN_W'(N_BYTES)) begin
            w_last_bit = BIT_CNT_W'(w_rem_bits - (LEN_W+3)'(1));
        end
    end

    assign bit_ready_o  = (r_state == ST_FILL);
    assign byte_valid_o = (r_state == ST_DRAIN);
    assign byte_o       = byte_valid_o ? w_bytes[r_byte_idx] : 8'h00;
    assign w_last_byte  = (r_remaining == LEN_W'(1));
    assign byte_last_o  = byte_valid_o && w_last_byte;
    assign busy_o       = (r_state != ST_IDLE);
    assign done_o       = (r_state == ST_DONE);
    assign dbg_state_o  = r_state;

    assign w_bit_hs   = bit_valid_i && bit_ready_o;
    assign w_byte_hs  = byte_valid_o && byte_ready_i;
    assign w_word_end = w_last_byte || (r_byte_idx == IDX_W'(N_BYTES - 1));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start_i) begin
                    w_state_nxt = (len_i == '0) ? ST_DONE : ST_FILL;
                end
            end
            ST_FILL: begin
                if (w_bit_hs && (r_bit_cnt == w_last_bit)) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_byte_hs && w_word_end) begin
                    w_state_nxt = w_last_byte ? ST_DONE : ST_FILL;
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= ST_IDLE;
            r_remaining <= '0;
            r_word      <= '0;
            r_bit_cnt   <= '0;
            r_byte_idx  <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                ST_IDLE: begin
                    if (start_i) begin
                        r_remaining <= len_i;
                        r_word      <= '0;
                        r_bit_cnt   <= '0;
                        r_byte_idx  <= '0;
                    end
                end
                ST_FILL: begin
                    if (w_bit_hs) begin
                        r_word[r_bit_cnt] <= bit_i;
                        r_bit_cnt         <= r_bit_cnt + BIT_CNT_W'(1);
                    end
                end
                ST_DRAIN: begin
                    if (w_byte_hs) begin
                        r_remaining <= r_remaining - LEN_W'(1);
                        r_byte_idx  <= r_byte_idx + IDX_W'(1);
                        // Re-entering FILL starts from an all-zero word so tail padding reads as 0.
                        if (w_word_end) begin
                            r_word     <= '0;
                            r_bit_cnt  <= '0;
                            r_byte_idx <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
